// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read-side and output-stream handshake bundle for fifo_rd_ctrl.
// The master view belongs to the controller: it reads the FIFO head and
// drives the output stream. The slave view belongs to the surrounding
// FIFO/stream environment.
interface fifo_rd_ctrl_if #(
    parameter int DSIZE = 32
);
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;

    modport master (
        input  rdata,
        input  rempty,
        input  m_ready,
        output rinc,
        output m_data,
        output m_valid,
        output m_last
    );

    modport slave (
        output rdata,
        output rempty,
        output m_ready,
        input  rinc,
        input  m_data,
        input  m_valid,
        input  m_last
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: pops a first-word-fall-through FIFO into a 2-entry
// in-order skid buffer and presents the words as a valid/ready stream with
// packet framing (m_last every PKT_LEN words). The pop strobe depends only on
// registered occupancy, never on m_ready, so the FIFO-side timing path is cut.
module fifo_rd_ctrl #(
    parameter int DSIZE   = 32,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic              rclk,
    input  logic              rrst,
    fifo_rd_ctrl_if.master    bus,
    input  logic              enable,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy
);

    // Packet index width; a 1-word packet still needs a 1-bit index register.
    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [1:0]         occ_q;
    logic [1:0]         occ_d;
    logic               hd_q;
    logic               hd_d;
    logic [DSIZE-1:0]   data_q [0:1];
    logic [DSIZE-1:0]   data_d [0:1];
    logic [1:0]         last_q;
    logic [1:0]         last_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               push_s;
    logic               pop_s;
    logic               tail_s;
    logic               word_last_s;

    // Pop strobe: only while running, enabled, FIFO non-empty, buffer not full,
    // and never during a reset cycle.
    always_comb begin
        push_s = 1'b0;
        if (rrst && (state_q == ST_RUN) && enable && !bus.rempty && (occ_q != 2'd2)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Output transfer and buffer addressing; tail sits occ entries past head.
    always_comb begin
        pop_s       = (occ_q != 2'd0) && bus.m_ready;
        tail_s      = hd_q ^ occ_q[0];
        word_last_s = (idx_q == LAST_IDX);
    end

    // Buffer, packet index and word counter next-state.
    always_comb begin
        data_d[0] = data_q[0];
        data_d[1] = data_q[1];
        last_d    = last_q;
        hd_d      = hd_q;
        occ_d     = occ_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;

        if (push_s) begin
            data_d[tail_s] = bus.rdata;
            last_d[tail_s] = word_last_s;
            if (word_last_s) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end

        if (pop_s) begin
            hd_d  = ~hd_q;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            hd_d  = hd_q;
            cnt_d = cnt_q;
        end

        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Controller state next-state: words left in the buffer keep flowing in DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (occ_q != 2'd0) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (occ_q == 2'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset; buffered words are discarded.
    always_ff @(posedge rclk) begin
        if (!rrst) begin
            state_q <= ST_IDLE;
            occ_q   <= 2'd0;
            hd_q    <= 1'b0;
            last_q  <= 2'b00;
            idx_q   <= {IDX_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            hd_q    <= hd_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data storage needs no reset: entries are only observed while occupied.
    always_ff @(posedge rclk) begin
        data_q[0] <= data_d[0];
        data_q[1] <= data_d[1];
    end

    // Outputs come straight from registers (head entry, occupancy, state).
    always_comb begin
        bus.rinc    = push_s;
        bus.m_valid = (occ_q != 2'd0);
        bus.m_data  = data_q[hd_q];
        bus.m_last  = (occ_q != 2'd0) && last_q[hd_q];
        word_cnt    = cnt_q;
        busy        = (state_q != ST_IDLE);
    end

endmodule
